// File: rtl/key_buffer_irq_pkg.sv
// Shared definitions for the keyboard FIFO with interrupt: bus address map,
// IRQ FSM states, vector codes and read-word layouts.
`ifndef KEY_BUFFER_IRQ_KEY_BASE_DEFINED
`define KEY_BUFFER_IRQ_KEY_BASE_DEFINED
`define Key_base 64'h0000_0000_FF20_0000
`endif

package key_buffer_irq_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE     = 2'd0,
        IRQ_PENDING  = 2'd1,
        IRQ_SERVICED = 2'd2
    } irq_state_e;

    localparam logic [3:0] IRQ_NONE = 4'd0;
    localparam logic [3:0] IRQ_KEY  = 4'd1;

    localparam int DATA_VALID_BIT = 31;
    localparam int DATA_CNT_LSB   = 8;
    localparam int STAT_DROP_LSB  = 16;
    localparam int STAT_OVF_BIT   = 8;
    localparam int STAT_CNT_LSB   = 0;

    localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

    function automatic logic [63:0] pack_data_word(input logic [3:0] cnt, input logic [7:0] head);
        logic [63:0] w;
        w = 64'd0;
        w[DATA_VALID_BIT]        = 1'b1;
        w[DATA_CNT_LSB +: 4]     = cnt;
        w[7:0]                   = head;
        return w;
    endfunction

    function automatic logic [63:0] pack_status_word(input logic [7:0] drops, input logic ovf,
                                                     input logic [4:0] cnt);
        logic [63:0] w;
        w = 64'd0;
        w[STAT_DROP_LSB +: 8] = drops;
        w[STAT_OVF_BIT]       = ovf;
        w[STAT_CNT_LSB +: 5]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/key_buffer_irq_sync_fifo.sv
// Power-of-two synchronous FIFO; a pop frees a slot for a push on the same edge,
// so a full FIFO still accepts a byte when it is being read.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // qualify requests against occupancy
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
    end

    // pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // storage needs no reset: stale entries are never visible past the pointers
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
    end

    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == '0);
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/key_buffer_irq.sv
// PS/2 key FIFO on the CPU bus: data register pops one key per read strobe,
// status register reports occupancy and drops, and a level IRQ flags new keys.
module key_buffer_irq #(
    parameter int          DEPTH    = 8,
    parameter logic [63:0] KEY_BASE = `Key_base
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_pressed,
    input  logic [7:0]  key_ascii,
    input  logic [63:0] bus_address,
    input  logic        bus_read_enable,
    output logic [63:0] bus_read_data,
    output logic        key_selected,
    output logic [3:0]  interrupt_vector,
    input  logic        interrupt_ack,
    output logic        overflow
);
    import key_buffer_irq_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic          key_d_r;
    logic          rd_d_r;
    logic          rst_hold_r;
    logic [63:0]   rd_data_r;
    logic          overflow_r;
    logic [7:0]    drop_cnt_r;
    logic [3:0]    irq_vec_r;
    irq_state_e    state_r;
    irq_state_e    state_next_s;

    logic          data_sel_s;
    logic          stat_sel_s;
    logic          rd_act_s;
    logic          rd_evt_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [4:0]    count5_s;
    logic [7:0]    fifo_head_s;

    // address decode and event qualification; rst_hold_r masks the first post-reset edge
    always_comb begin
        data_sel_s   = (bus_address == KEY_BASE);
        stat_sel_s   = (bus_address == (KEY_BASE + 64'd8));
        key_selected = data_sel_s || stat_sel_s;
        rd_act_s     = bus_read_enable && key_selected;
        rd_evt_s     = rd_act_s && !rd_d_r && !rst_hold_r;
        push_s       = key_pressed && !key_d_r && (key_ascii != 8'd0) && !rst_hold_r;
        pop_s        = rd_evt_s && data_sel_s && !fifo_empty_s;
        drop_s       = push_s && fifo_full_s && !pop_s;
        count5_s     = 5'(fifo_count_s);
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (key_ascii),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s),
        .head    (fifo_head_s)
    );

    // edge-detect history for key and read strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            key_d_r    <= 1'b0;
            rd_d_r     <= 1'b0;
            rst_hold_r <= 1'b1;
        end else begin
            key_d_r    <= key_pressed;
            rd_d_r     <= rd_act_s;
            rst_hold_r <= 1'b0;
        end
    end

    // read data is captured once per read event and held until the next one
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= 64'd0;
        end else if (rd_evt_s) begin
            if (data_sel_s) begin
                rd_data_r <= fifo_empty_s ? 64'd0 : pack_data_word(count5_s[3:0], fifo_head_s);
            end else begin
                rd_data_r <= pack_status_word(drop_cnt_r, overflow_r, count5_s);
            end
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    // sticky drop tracking; a drop landing on a status read is kept for the next read
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else if (rd_evt_s && stat_sel_s) begin
            overflow_r <= drop_s;
            drop_cnt_r <= drop_s ? 8'd1 : 8'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= (drop_cnt_r == DROP_CNT_MAX) ? DROP_CNT_MAX : drop_cnt_r + 8'd1;
        end else begin
            overflow_r <= overflow_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

    // IRQ next state: raise on data present, hold off after ack until drained
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IRQ_IDLE: begin
                if (fifo_count_s != '0) state_next_s = IRQ_PENDING;
                else                    state_next_s = IRQ_IDLE;
            end
            IRQ_PENDING: begin
                if (interrupt_ack) state_next_s = IRQ_SERVICED;
                else               state_next_s = IRQ_PENDING;
            end
            IRQ_SERVICED: begin
                if (fifo_count_s == '0) state_next_s = IRQ_IDLE;
                else                    state_next_s = IRQ_SERVICED;
            end
            default: state_next_s = IRQ_IDLE;
        endcase
    end

    // IRQ state and registered vector
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IRQ_IDLE;
            irq_vec_r <= IRQ_NONE;
        end else begin
            state_r   <= state_next_s;
            irq_vec_r <= (state_next_s == IRQ_PENDING) ? IRQ_KEY : IRQ_NONE;
        end
    end

    assign bus_read_data    = rd_data_r;
    assign interrupt_vector = irq_vec_r;
    assign overflow         = overflow_r;

endmodule

// File: tb/tb_key_buffer_irq.sv
// Self-checking bench for key_buffer_irq: directed scenarios plus a randomized run,
// all compared against a queue-based reference model stepped once per clock.
module tb_key_buffer_irq;
    localparam int          DEPTH      = 8;
    localparam logic [63:0] KB         = 64'h0000_0000_FF20_0000;
    localparam logic [63:0] ADDR_DATA  = KB;
    localparam logic [63:0] ADDR_STAT  = KB + 64'd8;
    localparam logic [63:0] ADDR_OTHER = KB + 64'd16;

    logic        clk;
    logic        reset;
    logic        key_pressed;
    logic [7:0]  key_ascii;
    logic [63:0] bus_address;
    logic        bus_read_enable;
    logic [63:0] bus_read_data;
    logic        key_selected;
    logic [3:0]  interrupt_vector;
    logic        interrupt_ack;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: key queue, sticky flags, held read word, interrupt phase
    logic [7:0]  mq[$];
    bit          m_ovf;
    int          m_drop;
    logic [63:0] m_rdata;
    int          m_irq;      // 0 quiet, 1 raised, 2 acknowledged and draining
    bit          m_key_prev;
    bit          m_rd_prev;
    bit          m_after_rst;

    key_buffer_irq #(.DEPTH(DEPTH), .KEY_BASE(KB)) dut (
        .clk              (clk),
        .reset            (reset),
        .key_pressed      (key_pressed),
        .key_ascii        (key_ascii),
        .bus_address      (bus_address),
        .bus_read_enable  (bus_read_enable),
        .bus_read_data    (bus_read_data),
        .key_selected     (key_selected),
        .interrupt_vector (interrupt_vector),
        .interrupt_ack    (interrupt_ack),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // advance the model for the coming edge, then clock and settle
    task automatic step();
        int cnt;
        bit sel_d, sel_s, push, rd, pop, drop;
        sel_d = (bus_address == ADDR_DATA);
        sel_s = (bus_address == ADDR_STAT);
        cnt   = mq.size();
        if (reset) begin
            mq.delete();
            m_ovf = 0; m_drop = 0; m_rdata = 64'd0; m_irq = 0;
            m_after_rst = 1; m_key_prev = 0; m_rd_prev = 0;
        end else begin
            push = key_pressed && !m_key_prev && (key_ascii != 8'd0) && !m_after_rst;
            rd   = bus_read_enable && (sel_d || sel_s) && !m_rd_prev && !m_after_rst;
            pop  = rd && sel_d && (cnt > 0);
            drop = push && (cnt == DEPTH) && !pop;
            if (rd && sel_d) m_rdata = (cnt > 0) ? {32'd0, 1'b1, 19'd0, 4'(cnt), mq[0]} : 64'd0;
            if (rd && sel_s) m_rdata = {40'd0, 8'(m_drop), 7'd0, m_ovf, 3'd0, 5'(cnt)};
            if (rd && sel_s) begin
                m_ovf  = drop;
                m_drop = drop ? 1 : 0;
            end else if (drop) begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
            case (m_irq)
                0: if (cnt != 0) m_irq = 1;
                1: if (interrupt_ack) m_irq = 2;
                2: if (cnt == 0) m_irq = 0;
                default: m_irq = 0;
            endcase
            if (pop) void'(mq.pop_front());
            if (push && !drop) mq.push_back(key_ascii);
            m_key_prev  = key_pressed;
            m_rd_prev   = bus_read_enable && (sel_d || sel_s);
            m_after_rst = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] ch, input int hold);
        key_ascii   = ch;
        key_pressed = 1'b1;
        repeat (hold) step();
        key_pressed = 1'b0;
        step();
    endtask

    task automatic read_reg(input logic [63:0] addr, input int hold);
        bus_address     = addr;
        bus_read_enable = 1'b1;
        repeat (hold) step();
        bus_read_enable = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1; key_pressed = 1'b0; bus_read_enable = 1'b0; interrupt_ack = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        key_ascii = 8'd0; bus_address = ADDR_OTHER;
        do_reset();
        n_checks++; if (bus_read_data !== 64'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus_read_data); end
        n_checks++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL reset_irq got %0d want 0", interrupt_vector); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
        n_checks++; if (key_selected !== 1'b0) begin n_fail++; $display("FAIL sel_other got %b want 0", key_selected); end
        bus_address = ADDR_DATA; #1;
        n_checks++; if (key_selected !== 1'b1) begin n_fail++; $display("FAIL sel_data got %b want 1", key_selected); end
        bus_address = ADDR_STAT; #1;
        n_checks++; if (key_selected !== 1'b1) begin n_fail++; $display("FAIL sel_stat got %b want 1", key_selected); end
        bus_address = KB + 64'd1; #1;
        n_checks++; if (key_selected !== 1'b0) begin n_fail++; $display("FAIL sel_base_plus1 got %b want 0", key_selected); end
        bus_address = ADDR_OTHER;
    endtask

    task automatic test_single_key();
        do_reset();
        press(8'h61, 100);
        read_reg(ADDR_DATA, 1);
        n_checks++; if (bus_read_data !== 64'h8000_0161) begin n_fail++; $display("FAIL held_key_read got %h want 80000161", bus_read_data); end
        n_checks++; if (bus_read_data !== m_rdata) begin n_fail++; $display("FAIL held_key_model got %h want %h", bus_read_data, m_rdata); end
        read_reg(ADDR_DATA, 1);
        n_checks++; if (bus_read_data !== 64'd0) begin n_fail++; $display("FAIL empty_read got %h want 0", bus_read_data); end
    endtask

    task automatic test_overflow();
        logic [7:0] keys [10];
        logic [63:0] exp;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            keys[i] = 8'($urandom_range(1, 255));
            press(keys[i], 1);
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
        read_reg(ADDR_STAT, 1);
        n_checks++; if (bus_read_data !== 64'h0000_0000_0002_0108) begin n_fail++; $display("FAIL stat_drop2 got %h want 20108", bus_read_data); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
        read_reg(ADDR_STAT, 1);
        n_checks++; if (bus_read_data !== 64'h8) begin n_fail++; $display("FAIL stat_after_clear got %h want 8", bus_read_data); end
        for (int i = 0; i < 8; i++) begin
            read_reg(ADDR_DATA, 1);
            exp = 64'h8000_0000 | (64'(8 - i) << 8) | 64'(keys[i]);
            n_checks++; if (bus_read_data !== exp) begin n_fail++; $display("FAIL ovf_drain%0d got %h want %h", i, bus_read_data, exp); end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < DEPTH + 260; i++) press(8'($urandom_range(1, 255)), 1);
        read_reg(ADDR_STAT, 1);
        n_checks++; if (bus_read_data !== 64'h00FF_0108) begin n_fail++; $display("FAIL drop_saturate got %h want ff0108", bus_read_data); end
    endtask

    task automatic test_irq();
        do_reset();
        interrupt_ack = 1'b1; step(); interrupt_ack = 1'b0; step();
        n_checks++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL irq_idle_ack got %0d want 0", interrupt_vector); end
        key_ascii = 8'h31; key_pressed = 1'b1;
        step();
        n_checks++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL irq_early got %0d want 0", interrupt_vector); end
        step();
        n_checks++; if (interrupt_vector !== 4'd1) begin n_fail++; $display("FAIL irq_raise got %0d want 1", interrupt_vector); end
        key_pressed = 1'b0;
        interrupt_ack = 1'b1; step(); interrupt_ack = 1'b0;
        n_checks++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL irq_ack got %0d want 0", interrupt_vector); end
        for (int i = 0; i < 2; i++) begin
            press(8'h32 + 8'(i), 1);
            step();
            n_checks++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL irq_serviced%0d got %0d want 0", i, interrupt_vector); end
        end
        for (int i = 0; i < 3; i++) begin
            read_reg(ADDR_DATA, 1);
            n_checks++; if (bus_read_data !== m_rdata) begin n_fail++; $display("FAIL irq_drain%0d got %h want %h", i, bus_read_data, m_rdata); end
        end
        step();
        key_ascii = 8'h39; key_pressed = 1'b1;
        step(); step();
        key_pressed = 1'b0;
        n_checks++; if (interrupt_vector !== 4'd1) begin n_fail++; $display("FAIL irq_reraise got %0d want 1", interrupt_vector); end
    endtask

    task automatic test_full_simul();
        logic [7:0]  exp_q[$];
        logic [7:0]  nk;
        logic [63:0] exp;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            nk = 8'($urandom_range(1, 255));
            exp_q.push_back(nk);
            press(nk, 1);
        end
        for (int r = 0; r < 5; r++) begin
            nk = 8'($urandom_range(1, 255));
            bus_address = ADDR_DATA; key_ascii = nk;
            key_pressed = 1'b1; bus_read_enable = 1'b1;
            step();
            key_pressed = 1'b0; bus_read_enable = 1'b0;
            step();
            exp = 64'h8000_0800 | 64'(exp_q.pop_front());
            exp_q.push_back(nk);
            n_checks++; if (bus_read_data !== exp) begin n_fail++; $display("FAIL simul_read%0d got %h want %h", r, bus_read_data, exp); end
            n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL simul_ovf%0d got %b want 0", r, overflow); end
        end
        read_reg(ADDR_STAT, 1);
        n_checks++; if (bus_read_data !== 64'h8) begin n_fail++; $display("FAIL simul_stat got %h want 8", bus_read_data); end
        for (int i = 0; i < DEPTH; i++) begin
            read_reg(ADDR_DATA, 1);
            exp = 64'h8000_0000 | (64'(DEPTH - i) << 8) | 64'(exp_q[i]);
            n_checks++; if (bus_read_data !== exp) begin n_fail++; $display("FAIL wrap_order%0d got %h want %h", i, bus_read_data, exp); end
        end
    endtask

    task automatic test_long_strobe();
        do_reset();
        press(8'h41, 1); press(8'h42, 1); press(8'h43, 1);
        read_reg(ADDR_DATA, 50);
        n_checks++; if (bus_read_data !== 64'h8000_0341) begin n_fail++; $display("FAIL long_strobe got %h want 80000341", bus_read_data); end
        read_reg(ADDR_STAT, 1);
        n_checks++; if (bus_read_data !== 64'h2) begin n_fail++; $display("FAIL long_strobe_pops got %h want 2", bus_read_data); end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        press(8'h44, 1); press(8'h45, 1); press(8'h46, 1);
        bus_address = ADDR_DATA; bus_read_enable = 1'b1;
        key_ascii = 8'h55; key_pressed = 1'b1;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step(); step();
        n_checks++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL rst_mid_irq got %0d want 0", interrupt_vector); end
        n_checks++; if (bus_read_data !== 64'd0) begin n_fail++; $display("FAIL rst_mid_rdata got %h want 0", bus_read_data); end
        bus_read_enable = 1'b0; key_pressed = 1'b0;
        step();
        read_reg(ADDR_STAT, 1);
        n_checks++; if (bus_read_data !== 64'd0) begin n_fail++; $display("FAIL rst_mid_count got %h want 0", bus_read_data); end
        read_reg(ADDR_DATA, 1);
        n_checks++; if (bus_read_data !== 64'd0) begin n_fail++; $display("FAIL rst_mid_next_read got %h want 0", bus_read_data); end
    endtask

    task automatic test_random();
        logic [63:0] addrs [3];
        addrs[0] = ADDR_DATA; addrs[1] = ADDR_STAT; addrs[2] = ADDR_OTHER;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (key_pressed) begin
                if ($urandom_range(0, 1) == 0) key_pressed = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                key_ascii   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                key_pressed = 1'b1;
            end
            if (bus_read_enable) begin
                if ($urandom_range(0, 2) == 0) bus_read_enable = 1'b0;
            end else begin
                bus_address = addrs[$urandom_range(0, 2)];
                if ($urandom_range(0, 3) == 0) bus_read_enable = 1'b1;
            end
            interrupt_ack = ($urandom_range(0, 5) == 0);
            step();
            n_checks++; if (bus_read_data !== m_rdata) begin n_fail++; $display("FAIL rand_rdata@%0d got %h want %h", i, bus_read_data, m_rdata); end
            n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand_ovf@%0d got %b want %b", i, overflow, m_ovf); end
            n_checks++; if (interrupt_vector !== ((m_irq == 1) ? 4'd1 : 4'd0)) begin n_fail++; $display("FAIL rand_irq@%0d got %0d want state %0d", i, interrupt_vector, m_irq); end
        end
        interrupt_ack = 1'b0; bus_read_enable = 1'b0; key_pressed = 1'b0;
    endtask

    initial begin
        reset = 1'b1; key_pressed = 1'b0; key_ascii = 8'd0;
        bus_address = ADDR_OTHER; bus_read_enable = 1'b0; interrupt_ack = 1'b0;
        test_reset();
        test_single_key();
        test_overflow();
        test_saturate();
        test_irq();
        test_full_simul();
        test_long_strobe();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_buffer_irq.md
KEY_BUFFER_IRQ -- requirements
Module: key_buffer_irq

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the FIFO entry count; it SHALL be a power of two, 2 to 16.
REQ-002 The block SHALL have parameter KEY_BASE, default `Key_base, meaning the 64-bit data-register address; the status register SHALL sit at KEY_BASE+8.
REQ-003 Port clk, input, 1 bit: single clock, 50 MHz domain of the PS/2 decoder and bus.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port key_pressed, input, 1 bit: level from the PS/2 decoder, high while a make code is held.
REQ-006 Port key_ascii, input, 8 bits: decoder ASCII, stable while key_pressed is high.
REQ-007 Port bus_address, input, 64 bits: CPU bus address.
REQ-008 Port bus_read_enable, input, 1 bit: CPU read strobe; it may stay high for many clk cycles.
REQ-009 Port bus_read_data, output, 64 bits: registered read data.
REQ-010 Port key_selected, output, 1 bit: combinational high when bus_address equals KEY_BASE or KEY_BASE+8.
REQ-011 Port interrupt_vector, output, 4 bits: 0 means none; 1 means keyboard.
REQ-012 Port interrupt_ack, input, 1 bit: CPU acknowledge, level.
REQ-013 Port overflow, output, 1 bit: sticky drop flag.

Function
REQ-014 A push SHALL occur on the cycle after the key_pressed rising edge, using a one-flop delay, when key_ascii != 0; held keys SHALL push once.
REQ-015 If the FIFO is full at push time and no pop occurs that cycle, the byte SHALL be dropped, overflow SHALL be set, and drop_cnt SHALL increment, saturating at 8'hFF.
REQ-016 A read event SHALL be the rising edge of (bus_read_enable && key_selected), so a multi-cycle strobe yields exactly one event.
REQ-017 On a data-register read event with the FIFO non-empty, the next cycle bus_read_data SHALL be {32'd0, 1'b1, 19'd0, count[3:0], head[7:0]}, with count taken before the pop, and the head SHALL be popped.
REQ-018 On a data-register read event with the FIFO empty, the next cycle bus_read_data SHALL be 64'd0 with no pointer change.
REQ-019 On a status read event, bus_read_data SHALL be {40'd0, drop_cnt[7:0], 7'd0, overflow, 3'd0, count[4:0]}, and overflow and drop_cnt SHALL clear on the same edge.
REQ-020 bus_read_data SHALL hold its value until the next read event.
REQ-021 A simultaneous push and pop SHALL both succeed, including when full, and count SHALL stay unchanged.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-023 The IRQ FSM SHALL have three states: IDLE, PENDING, SERVICED.
REQ-024 IDLE -> PENDING SHALL occur when count != 0.
REQ-025 PENDING -> SERVICED SHALL occur on interrupt_ack == 1.
REQ-026 SERVICED -> IDLE SHALL occur when count == 0.
REQ-027 interrupt_vector SHALL be 4'd1 only in PENDING, so it asserts one cycle after count becomes non-zero and deasserts the cycle after ack.
REQ-028 Pushes in SERVICED SHALL NOT re-raise the interrupt; software drains the FIFO.
REQ-029 An ack in IDLE or SERVICED SHALL be ignored.

Reset
REQ-030 Reset SHALL zero the pointers, count, overflow, drop_cnt, bus_read_data and the edge-detect flops, force interrupt_vector to 0 and the FSM to IDLE, and discard buffered data; FIFO RAM contents are don't-care.
REQ-031 Reset asserted mid-read or mid-push SHALL win over that event, and the first cycle after reset SHALL perform no push or pop even if key_pressed or the strobe is already high.

Structure
REQ-032 The IRQ FSM state typedef, the IRQ_KEY=4'd1 vector code and the status bit positions SHALL live in the shared header alongside `Key_base.
REQ-033 The FIFO storage and pointers SHALL be one sub-module, sync_fifo (DEPTH, WIDTH=8), exposing push, pop, full, empty, count and head.

Verification
REQ-034 Press 'a' (8'h61) held for 100 cycles, then read the data register -> exactly one push; read returns 64'h8000_0161; the following read returns 0.
REQ-035 Push 10 keys with DEPTH=8 -> overflow=1; status read returns drop_cnt=2, count=8; a second status read shows overflow=0 and drop_cnt=0.
REQ-036 Push 1 key -> interrupt_vector=1 after 2 cycles; ack -> 0 next cycle; push 2 more -> stays 0; drain 3 -> IDLE; the next push re-raises the interrupt.
REQ-037 FIFO full, with a push and a pop on the same cycle -> count stays 8, overflow stays 0, FIFO order preserved across wrap.
REQ-038 Hold bus_read_enable for 50 cycles on the data register -> exactly one pop.
REQ-039 Assert reset during a read strobe with 3 keys buffered -> count=0, interrupt_vector=0, and the next read returns 0.
